// File: rtl/sipo_deframer.sv
// Serial-in, parallel-out deframer: assembles framed serial bits into WIDTH-bit words
// and flags words that are abandoned by a mid-word frame_sync.
//
// state | meaning
// IDLE  | waiting for a bit carrying frame_sync
// SHIFT | partial word in progress, bit_count bits received
module sipo_deframer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         serial_in,
  input  logic                         bit_valid,
  input  logic                         frame_sync,
  output logic [WIDTH-1:0]             parallel_out,
  output logic                         word_valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         sync_err
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wv_q, wv_d;
  logic             se_q, se_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seed;

  // seed is the register image after a frame_sync bit: only this bit kept
  always_comb begin
    shifted = '0;
    seed    = '0;
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], serial_in};
      seed    = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin
      shifted = {serial_in, sr_q[WIDTH-1:1]};
      seed    = {serial_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pout_d  = pout_q;
    cnt_d   = cnt_q;
    wv_d    = 1'b0;
    se_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid && frame_sync) begin
          sr_d    = seed;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (frame_sync) begin
            sr_d  = seed;
            cnt_d = CW'(1);
            se_d  = 1'b1;
          end else if (cnt_q == CW'(WIDTH-1)) begin
            sr_d    = shifted;
            pout_d  = shifted;
            wv_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pout_q  <= '0;
      cnt_q   <= '0;
      wv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      wv_q    <= wv_d;
      se_q    <= se_d;
    end
  end

  assign parallel_out = pout_q;
  assign word_valid   = wv_q;
  assign busy         = (state_q == SHIFT);
  assign bit_count    = cnt_q;
  assign sync_err     = se_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: MSB-first and LSB-first instances share one stimulus stream
// and are checked every cycle against a bit-list model plus literal expectations.
module tb_sipo_deframer;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] pout_m, pout_l;
  logic       wv_m, wv_l, busy_m, busy_l, se_m, se_l;
  logic [3:0] cnt_m, cnt_l;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .parallel_out(pout_m), .word_valid(wv_m),
    .busy(busy_m), .bit_count(cnt_m), .sync_err(se_m));

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .parallel_out(pout_l), .word_valid(wv_l),
    .busy(busy_l), .bit_count(cnt_l), .sync_err(se_l));

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         se_count = 0;
  int         wv_times[$];
  logic [7:0] wv_words[$];

  // model: list of bits received since the last frame_sync
  bit         in_word = 1'b0;
  int         nb = 0;
  bit         bits_q[W];
  logic [7:0] exp_m = '0, exp_l = '0;
  logic       exp_wv = 1'b0, exp_se = 1'b0;

  int gap_tab[8] = '{0, 1, 2, 3, 0, 3, 1, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic s, input logic v, input logic f);
    exp_wv = 1'b0;
    exp_se = 1'b0;
    if (v) begin
      if (f) begin
        if (in_word) exp_se = 1'b1;
        in_word = 1'b1;
        bits_q[0] = s;
        nb = 1;
      end else if (in_word) begin
        bits_q[nb] = s;
        nb++;
        if (nb == W) begin
          exp_m = '0;
          exp_l = '0;
          for (int i = 0; i < W; i++) begin
            exp_m = exp_m | (8'(bits_q[i]) << (W-1-i));
            exp_l = exp_l | (8'(bits_q[i]) << i);
          end
          exp_wv  = 1'b1;
          in_word = 1'b0;
          nb      = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      in_word = 1'b0; nb = 0; exp_m = '0; exp_l = '0; exp_wv = 1'b0; exp_se = 1'b0;
    end else begin
      model_step(serial_in, bit_valid, frame_sync);
    end
    cyc++;
    #1;
    chk("parallel_out msb", pout_m, exp_m);
    chk("parallel_out lsb", pout_l, exp_l);
    chk("word_valid msb", wv_m, exp_wv);
    chk("word_valid lsb", wv_l, exp_wv);
    chk("sync_err msb", se_m, exp_se);
    chk("sync_err lsb", se_l, exp_se);
    chk("busy msb", busy_m, in_word);
    chk("busy lsb", busy_l, in_word);
    chk("bit_count msb", cnt_m, nb[3:0]);
    chk("bit_count lsb", cnt_l, nb[3:0]);
    if (wv_m) begin
      wv_times.push_back(cyc);
      wv_words.push_back(pout_m);
    end
    if (se_m) se_count++;
  end

  task automatic send(input logic b, input logic fs);
    @(negedge clk);
    serial_in  = b;
    bit_valid  = 1'b1;
    frame_sync = fs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid  = 1'b0;
      frame_sync = 1'b0;
      serial_in  = 1'b0;
    end
  endtask

  // w is given in transmission order: w[7] goes first
  task automatic send_word(input logic [7:0] w, input int gapmax);
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && gapmax > 0) idle(gap_tab[i] % (gapmax + 1));
      send(w[7-i], i == 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset parallel_out", pout_m, 8'h00);
    chk("reset busy", busy_m, 1'b0);
    chk("reset bit_count", cnt_m, 4'd0);

    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    idle(1);
    chk("unsynced busy", busy_m, 1'b0);
    chk("unsynced word_valid", wv_m, 1'b0);

    send_word(8'hA5, 0);
    idle(1);
    chk("A5 msb", pout_m, 8'hA5);
    chk("A5 lsb", pout_l, 8'hA5);
    chk("A5 word_valid", wv_m, 1'b1);
    chk("A5 busy", busy_m, 1'b0);
    chk("model A5", exp_m, 8'hA5);
    idle(1);
    chk("A5 word_valid drop", wv_m, 1'b0);
    chk("A5 held", pout_m, 8'hA5);

    send_word(8'hC0, 0);
    idle(1);
    chk("C0 lsb", pout_l, 8'h03);
    chk("C0 msb", pout_m, 8'hC0);
    chk("model 03", exp_l, 8'h03);

    send_word(8'h3C, 3);
    idle(1);
    chk("gapped msb", pout_m, 8'h3C);
    chk("gapped lsb", pout_l, 8'h3C);
    idle(2);

    send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    send_word(8'hF0, 0);
    idle(1);
    chk("resync msb", pout_m, 8'hF0);
    chk("resync lsb", pout_l, 8'h0F);
    chk("resync sync_err count", se_count, 1);
    idle(2);

    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    frame_sync = 1'b0;
    reset = 1'b1;
    #1;
    chk("async reset parallel_out", pout_m, 8'h00);
    chk("async reset busy", busy_m, 1'b0);
    chk("async reset bit_count", cnt_m, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    wv_times.delete();
    wv_words.delete();

    send_word(8'h81, 0);
    send_word(8'h7E, 0);
    idle(1);
    chk("b2b msb", pout_m, 8'h7E);
    chk("b2b lsb", pout_l, 8'h7E);
    chk("b2b pulse count", wv_times.size(), 2);
    if (wv_times.size() == 2) begin
      chk("b2b first word", wv_words[0], 8'h81);
      chk("b2b spacing", wv_times[1] - wv_times[0], 8);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
